// File: rtl/ram_ctrl_pkg.sv
// Shared types and default geometry for the register-file RAM controller.
package ram_ctrl_pkg;

  localparam int DEFAULT_ROWS   = 8;
  localparam int DEFAULT_WIDTH  = 11;
  localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_ROWS);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_id_t;

endpackage

// File: rtl/ram_row_decoder.sv
// Turns a row address into a one-hot row select; addresses beyond the last
// row (possible when ROWS is not a power of two) select nothing.
module ram_row_decoder
  import ram_ctrl_pkg::*;
#(
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [ROWS-1:0]   sel
);

  logic in_range;

  always_comb begin
    in_range = ({{(32-ADDR_W){1'b0}}, addr} < ROWS);
    sel      = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (en && in_range && (addr == ADDR_W'(i))) begin
        sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one write port of the register-file RAM between the CPU (A) and the
// loader (B), gives each its own read port, and sequences a full clear.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_ready,
  output logic              a_rsp_valid,
  output logic [WIDTH-1:0]  a_rsp_data,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_ready,
  output logic              b_rsp_valid,
  output logic [WIDTH-1:0]  b_rsp_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ROWS-1:0]   ram_wsel,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic [ROWS-1:0]   ram_rsel1,
  output logic [ROWS-1:0]   ram_rsel2,
  input  logic [WIDTH-1:0]  ram_rdata1,
  input  logic [WIDTH-1:0]  ram_rdata2
);

  clr_state_t        state, next_state;
  req_id_t           last_grant;
  logic [ADDR_W-1:0] cnt;
  logic              last_row;

  logic              a_wr, b_wr;
  logic              a_win, b_win;
  logic              w_en, r1_en, r2_en;
  logic [ADDR_W-1:0] w_addr;
  logic              a_hit, b_hit;

  assign last_row = (cnt == ADDR_W'(ROWS - 1));
  assign a_wr     = a_valid & a_we;
  assign b_wr     = b_valid & b_we;
  assign a_hit    = ({{(32-ADDR_W){1'b0}}, a_addr} < ROWS);
  assign b_hit    = ({{(32-ADDR_W){1'b0}}, b_addr} < ROWS);

  // Holding reset low forces every handshake and select inactive immediately,
  // not just after the next edge.
  always_comb begin
    next_state = state;
    a_win      = 1'b0;
    b_win      = 1'b0;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    w_en       = 1'b0;
    w_addr     = '0;
    ram_wdata  = '0;
    r1_en      = 1'b0;
    r2_en      = 1'b0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (clr_start) begin
            next_state = CLEAR;
          end
          // On a tie the requester that did not win last time gets the port.
          a_win   = a_wr & (~b_wr | (last_grant == REQ_B));
          b_win   = b_wr & (~a_wr | (last_grant == REQ_A));
          a_ready = a_valid & (~a_we | a_win);
          b_ready = b_valid & (~b_we | b_win);
          r1_en   = a_valid & ~a_we;
          r2_en   = b_valid & ~b_we;
          w_en    = a_win | b_win;
          if (a_win) begin
            w_addr    = a_addr;
            ram_wdata = a_wdata;
          end else if (b_win) begin
            w_addr    = b_addr;
            ram_wdata = b_wdata;
          end
        end
        CLEAR: begin
          w_en   = 1'b1;
          w_addr = cnt;
          if (last_row) begin
            next_state = DONE;
          end
        end
        DONE: begin
          next_state = IDLE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  ram_row_decoder #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_wdec (
    .addr (w_addr),
    .en   (w_en),
    .sel  (ram_wsel)
  );

  ram_row_decoder #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_rdec1 (
    .addr (a_addr),
    .en   (r1_en),
    .sel  (ram_rsel1)
  );

  ram_row_decoder #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_rdec2 (
    .addr (b_addr),
    .en   (r2_en),
    .sel  (ram_rsel2)
  );

  // busy/done are registered from next_state so they line up with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= REQ_B;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
    end else begin
      state    <= next_state;
      clr_busy <= (next_state == CLEAR);
      clr_done <= (next_state == DONE);
      if (state == CLEAR) begin
        cnt <= last_row ? '0 : cnt + ADDR_W'(1);
      end
      if (a_win) begin
        last_grant <= REQ_A;
      end else if (b_win) begin
        last_grant <= REQ_B;
      end
    end
  end

  // Writes echo their data; reads outside the array return zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_rsp_valid <= 1'b0;
      a_rsp_data  <= '0;
      b_rsp_valid <= 1'b0;
      b_rsp_data  <= '0;
    end else begin
      a_rsp_valid <= a_ready;
      b_rsp_valid <= b_ready;
      if (a_ready) begin
        a_rsp_data <= a_we ? a_wdata : (a_hit ? ram_rdata1 : '0);
      end
      if (b_ready) begin
        b_rsp_data <= b_we ? b_wdata : (b_hit ? ram_rdata2 : '0);
      end
    end
  end

endmodule
